// File: rtl/cp_serializer_pkg.sv
// Shared types for the FFT output path and the transmit-side cyclic-prefix serializer.
package cp_serializer_pkg;

    localparam int CP_W = 16;

    typedef struct packed {
        logic signed [CP_W-1:0] re;
        logic signed [CP_W-1:0] im;
    } complex_product_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        BODY = 2'd2
    } cp_state_t;

endpackage

// File: rtl/cp_serializer_if.sv
// Frame-in / beat-out bundle of cp_serializer; master drives frames and out_ready.
interface cp_serializer_if #(
    parameter int N = 8
);
    import cp_serializer_pkg::*;

    complex_product_t [N-1:0] frame_in;
    logic                     in_valid;
    logic                     in_ready;
    complex_product_t         data_out_0;
    complex_product_t         data_out_1;
    logic                     out_valid;
    logic                     out_ready;
    logic                     frame_start;
    logic                     frame_end;

    modport master (
        output frame_in, in_valid, out_ready,
        input  in_ready, data_out_0, data_out_1, out_valid, frame_start, frame_end
    );

    modport slave (
        input  frame_in, in_valid, out_ready,
        output in_ready, data_out_0, data_out_1, out_valid, frame_start, frame_end
    );

endinterface

// File: rtl/cp_serializer_buf.sv
// Two-slot ping-pong frame store with wr/rd/occ bookkeeping and a two-sample read port.
module pingpong_frame_buffer import cp_serializer_pkg::*; #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  complex_product_t [N-1:0] wr_frame,
    input  logic                     rls,
    input  logic                     rd_ahead,
    input  logic [IW-1:0]            rd_idx,
    output complex_product_t         rd_data_0,
    output complex_product_t         rd_data_1,
    output logic                     full,
    output logic                     empty
);

    complex_product_t [1:0][N-1:0] mem_q, mem_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] occ_q, occ_d;
    logic       full_q, full_d;
    logic       empty_q, empty_d;
    logic          rd_slot;
    logic [IW-1:0] rd_idx_odd;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_q] = wr_frame;
        wr_d  = wr_q ^ wr_en;
        rd_d  = rd_q ^ rls;
        occ_d = occ_q;
        case ({wr_en, rls})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        full_d  = (occ_d == 2'd2);
        empty_d = (occ_d == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // rd_ahead peeks at the slot after rd so the next frame can start on the release edge.
    always_comb begin
        rd_slot    = rd_q ^ rd_ahead;
        rd_idx_odd = {rd_idx[IW-1:1], 1'b1};
        rd_data_0  = mem_q[rd_slot][rd_idx];
        rd_data_1  = mem_q[rd_slot][rd_idx_odd];
    end

    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/cp_serializer.sv
// Streams buffered N-sample frames two samples per beat, cyclic prefix first, then body.
module cp_serializer import cp_serializer_pkg::*; #(
    parameter int N      = 8,
    parameter int CP_LEN = 2
) (
    input logic            clk,
    input logic            reset,
    cp_serializer_if.slave bus
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N / 2);
    localparam logic [CW-1:0] BODY_LAST = CW'(N / 2 - 1);
    localparam logic [CW-1:0] CP_LAST   = (CP_LEN > 0) ? CW'(CP_LEN / 2 - 1) : '0;
    localparam logic [IW-1:0] CP_BASE   = IW'(N - CP_LEN);
    localparam cp_state_t     FIRST_ST  = cp_state_t'((CP_LEN > 0) ? CP : BODY);

    cp_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             fstart_q, fstart_d;
    logic             fend_q, fend_d;
    complex_product_t dout0_q, dout0_d;
    complex_product_t dout1_q, dout1_d;

    logic             accept, rls, advance;
    logic             rd_ahead, bypass;
    logic             buf_full, buf_empty;
    logic [IW-1:0]    rd_idx, idx_odd;
    complex_product_t buf_s0, buf_s1, src_s0, src_s1;

    assign accept  = bus.in_valid & ~buf_full;
    assign rls     = valid_q & bus.out_ready & fend_q;
    assign advance = ~valid_q | bus.out_ready;

    pingpong_frame_buffer #(.N(N)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (accept),
        .wr_frame  (bus.frame_in),
        .rls       (rls),
        .rd_ahead  (rd_ahead),
        .rd_idx    (rd_idx),
        .rd_data_0 (buf_s0),
        .rd_data_1 (buf_s1),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Next beat position; a frame arriving into an empty store is taken straight from frame_in.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        rd_ahead = 1'b0;
        bypass   = 1'b0;
        if (advance) begin
            if (valid_q && !fend_q) begin
                valid_d = 1'b1;
                if (state_q == CP && cnt_q == CP_LAST) begin
                    state_d = BODY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                state_d = FIRST_ST;
                cnt_d   = '0;
                valid_d = 1'b1;
                if (valid_q ? buf_full : !buf_empty) begin
                    rd_ahead = valid_q;
                end else if (accept) begin
                    bypass = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        end
    end

    always_comb begin
        rd_idx  = (state_d == CP) ? CP_BASE + {cnt_d, 1'b0} : {cnt_d, 1'b0};
        idx_odd = {rd_idx[IW-1:1], 1'b1};
        src_s0  = bypass ? bus.frame_in[rd_idx]  : buf_s0;
        src_s1  = bypass ? bus.frame_in[idx_odd] : buf_s1;

        dout0_d  = dout0_q;
        dout1_d  = dout1_q;
        fstart_d = fstart_q;
        fend_d   = fend_q;
        if (advance) begin
            dout0_d  = valid_d ? src_s0 : '0;
            dout1_d  = valid_d ? src_s1 : '0;
            fstart_d = valid_d && state_d == FIRST_ST && cnt_d == '0;
            fend_d   = valid_d && state_d == BODY && cnt_d == BODY_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            fstart_q <= 1'b0;
            fend_q   <= 1'b0;
            dout0_q  <= '0;
            dout1_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            fstart_q <= fstart_d;
            fend_q   <= fend_d;
            dout0_q  <= dout0_d;
            dout1_q  <= dout1_d;
        end
    end

    assign bus.in_ready    = ~buf_full;
    assign bus.out_valid   = valid_q;
    assign bus.frame_start = fstart_q;
    assign bus.frame_end   = fend_q;
    assign bus.data_out_0  = dout0_q;
    assign bus.data_out_1  = dout1_q;

endmodule

// File: tb/tb_cp_serializer.sv
// Self-checking bench for cp_serializer: N=8/CP_LEN=2 and N=16/CP_LEN=0 instances.
module tb_cp_serializer;
    import cp_serializer_pkg::*;

    typedef complex_product_t [15:0] frame_t;
    typedef struct packed {
        complex_product_t d0;
        complex_product_t d1;
        logic             fs;
        logic             fe;
    } beat_t;

    localparam int TMAX = 512;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp_serializer_if #(.N(8))  bus_a ();
    cp_serializer_if #(.N(16)) bus_b ();

    cp_serializer #(.N(8), .CP_LEN(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    cp_serializer #(.N(16), .CP_LEN(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_pass  = 0;
    int n_total = 0;

    beat_t  exp_q[$];
    beat_t  obs_q[$];
    int     mocc;
    int     mbeat;
    logic   plan_v[$];
    logic   plan_r[$];
    frame_t plan_f[$];

    logic  tr_ov[TMAX];
    logic  tr_ir[TMAX];
    logic  tr_mrdy[TMAX];
    logic  tr_hs[TMAX];
    beat_t tr_bt[TMAX];

    function automatic frame_t ramp(input int base);
        frame_t f;
        for (int i = 0; i < 16; i++) begin
            f[i].re = 16'(base + i);
            f[i].im = 16'(-(base + i));
        end
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < 16; i++) begin
            f[i].re = 16'($urandom);
            f[i].im = 16'($urandom);
        end
        return f;
    endfunction

    // Reference: a frame becomes B beats, prefix samples taken from the frame tail.
    function automatic void model_push(input frame_t f, input int n, input int cp);
        int    b;
        int    s;
        beat_t bt;
        b = (n + cp) / 2;
        for (int p = 0; p < b; p++) begin
            s = (p < cp / 2) ? n - cp + 2 * p : 2 * (p - cp / 2);
            bt.d0 = f[s];
            bt.d1 = f[s + 1];
            bt.fs = (p == 0);
            bt.fe = (p == b - 1);
            exp_q.push_back(bt);
        end
    endfunction

    task automatic idle_inputs();
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_a.frame_in  = '0;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b1;
        bus_b.frame_in  = '0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        plan_v.delete();
        plan_r.delete();
        plan_f.delete();
        mocc  = 0;
        mbeat = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    // Applies planned stimulus for a fixed number of cycles, recording traces and handshaken beats.
    task automatic run(input int sel, input int cycles);
        int     n, cp, b;
        logic   v, r, ov, ir;
        frame_t f;
        beat_t  bt;
        n = (sel != 0) ? 16 : 8;
        cp = (sel != 0) ? 0 : 2;
        b = (n + cp) / 2;
        obs_q.delete();
        for (int c = 0; c < cycles; c++) begin
            v = 1'b0;
            r = 1'b1;
            f = '0;
            if (plan_v.size() > 0) begin
                v = plan_v.pop_front();
                f = plan_f.pop_front();
            end
            if (plan_r.size() > 0) r = plan_r.pop_front();
            if (sel == 0) begin
                bus_a.in_valid = v; bus_a.frame_in = f[7:0]; bus_a.out_ready = r;
            end else begin
                bus_b.in_valid = v; bus_b.frame_in = f; bus_b.out_ready = r;
            end
            @(negedge clk);
            if (sel == 0) begin
                ov = bus_a.out_valid; ir = bus_a.in_ready;
                bt.d0 = bus_a.data_out_0; bt.d1 = bus_a.data_out_1;
                bt.fs = bus_a.frame_start; bt.fe = bus_a.frame_end;
            end else begin
                ov = bus_b.out_valid; ir = bus_b.in_ready;
                bt.d0 = bus_b.data_out_0; bt.d1 = bus_b.data_out_1;
                bt.fs = bus_b.frame_start; bt.fe = bus_b.frame_end;
            end
            tr_ov[c]   = ov;
            tr_ir[c]   = ir;
            tr_bt[c]   = bt;
            tr_mrdy[c] = (mocc < 2);
            tr_hs[c]   = 1'b0;
            if (v && mocc < 2) begin
                model_push(f, n, cp);
                mocc++;
            end
            if (ov && r) begin
                obs_q.push_back(bt);
                tr_hs[c] = 1'b1;
                mbeat++;
                if (mbeat == b) begin
                    mbeat = 0;
                    mocc--;
                end
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        logic             ov, ir, fs, fe;
        complex_product_t d0, d1;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                ov = bus_a.out_valid; ir = bus_a.in_ready; fs = bus_a.frame_start;
                fe = bus_a.frame_end; d0 = bus_a.data_out_0; d1 = bus_a.data_out_1;
            end else begin
                ov = bus_b.out_valid; ir = bus_b.in_ready; fs = bus_b.frame_start;
                fe = bus_b.frame_end; d0 = bus_b.data_out_0; d1 = bus_b.data_out_1;
            end
            n_total++; if (ov !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", s, ov); else n_pass++;
            n_total++; if (ir !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b want 1", s, ir); else n_pass++;
            n_total++; if (fs !== 1'b0) $display("FAIL reset_frame_start[%0d]: got %b want 0", s, fs); else n_pass++;
            n_total++; if (fe !== 1'b0) $display("FAIL reset_frame_end[%0d]: got %b want 0", s, fe); else n_pass++;
            n_total++; if (d0 !== '0) $display("FAIL reset_data_out_0[%0d]: got %h want 0", s, d0); else n_pass++;
            n_total++; if (d1 !== '0) $display("FAIL reset_data_out_1[%0d]: got %h want 0", s, d1); else n_pass++;
        end
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_basic();
        int nv;
        do_reset();
        plan_v.push_back(1'b1); plan_f.push_back(ramp(0));
        run(0, 10);
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL basic_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (tr_ov[0] !== 1'b0 || tr_ov[1] !== 1'b1) $display("FAIL basic_latency: valid c0=%b c1=%b want 0,1", tr_ov[0], tr_ov[1]);
        else n_pass++;
        n_total++;
        if (tr_bt[1].d0.re !== 16'sd6 || tr_bt[1].d1.re !== 16'sd7)
            $display("FAIL basic_first_prefix: got (%0d,%0d) want (6,7)", tr_bt[1].d0.re, tr_bt[1].d1.re);
        else n_pass++;
        nv = 0;
        for (int c = 1; c <= 5; c++) nv += int'(tr_hs[c]);
        n_total++;
        if (nv !== 5 || tr_ov[6] !== 1'b0) $display("FAIL basic_span: got %0d beats in cycles 1-5, c6 valid=%b want 5,0", nv, tr_ov[6]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nv;
        do_reset();
        plan_v.push_back(1'b1); plan_f.push_back(ramp(0));
        plan_v.push_back(1'b1); plan_f.push_back(ramp(100));
        run(0, 14);
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        nv = 0;
        for (int c = 1; c <= 10; c++) nv += int'(tr_hs[c]);
        n_total++;
        if (nv !== 10) $display("FAIL b2b_contiguous: got %0d beats in cycles 1-10 want 10", nv);
        else n_pass++;
        n_total++;
        if (tr_bt[6].d0.re !== 16'sd106 || tr_bt[6].fs !== 1'b1)
            $display("FAIL b2b_second_start: got re=%0d fs=%b want 106,1", tr_bt[6].d0.re, tr_bt[6].fs);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int last_hs;
        do_reset();
        plan_v.push_back(1'b1); plan_f.push_back(ramp(0));
        plan_r.push_back(1'b1); plan_r.push_back(1'b1);
        repeat (3) plan_r.push_back(1'b0);
        run(0, 12);
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL bp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        for (int c = 2; c <= 5; c++) begin
            n_total++;
            if (tr_ov[c] !== 1'b1 || tr_bt[c] !== exp_q[1])
                $display("FAIL bp_hold_c%0d: got valid=%b %h want 1 %h", c, tr_ov[c], tr_bt[c], exp_q[1]);
            else n_pass++;
        end
        last_hs = -1;
        for (int c = 0; c < 12; c++) if (tr_hs[c]) last_hs = c;
        n_total++;
        if (last_hs !== 8) $display("FAIL bp_late_end: got last beat cycle %0d want 8", last_hs);
        else n_pass++;
    endtask

    task automatic test_full();
        int h, k;
        do_reset();
        plan_v.push_back(1'b1); plan_f.push_back(ramp(0));
        plan_v.push_back(1'b1); plan_f.push_back(ramp(100));
        plan_v.push_back(1'b1); plan_f.push_back(ramp(200));
        repeat (5) plan_r.push_back(1'b0);
        run(0, 20);
        for (int c = 0; c < 20; c++) begin
            n_total++;
            if (tr_ir[c] !== tr_mrdy[c]) $display("FAIL full_in_ready_c%0d: got %b want %b", c, tr_ir[c], tr_mrdy[c]);
            else n_pass++;
        end
        n_total++;
        if (tr_ir[2] !== 1'b0) $display("FAIL full_drop: in_ready at third frame got %b want 0", tr_ir[2]);
        else n_pass++;
        n_total++;
        if (obs_q.size() !== 10) $display("FAIL full_count: got %0d beats want 10", obs_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL full_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        h = -1;
        k = 0;
        for (int c = 0; c < 20; c++) if (tr_hs[c]) begin
            k++;
            if (k == 5) h = c;
        end
        n_total++;
        if (h < 0 || tr_ir[h] !== 1'b0 || tr_ir[h + 1] !== 1'b1)
            $display("FAIL full_ready_return: frame1 end cycle %0d, in_ready there/after got %b/%b want 0/1", h, tr_ir[h], tr_ir[h + 1]);
        else n_pass++;
    endtask

    task automatic test_no_prefix();
        do_reset();
        plan_v.push_back(1'b1); plan_f.push_back(ramp(0));
        run(1, 12);
        n_total++;
        if (obs_q.size() !== 8) $display("FAIL nocp_count: got %0d beats want 8", obs_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL nocp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (tr_bt[8].fe !== 1'b1 || tr_bt[8].d1.re !== 16'sd15)
            $display("FAIL nocp_last: got fe=%b re=%0d want 1,15", tr_bt[8].fe, tr_bt[8].d1.re);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        plan_v.push_back(1'b1); plan_f.push_back(ramp(0));
        plan_v.push_back(1'b1); plan_f.push_back(ramp(100));
        run(0, 4);
        n_total++;
        if (bus_a.out_valid !== 1'b1 || bus_a.data_out_0.re !== 16'sd4)
            $display("FAIL mid_pre: got valid=%b re=%0d want 1,4", bus_a.out_valid, bus_a.data_out_0.re);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (bus_a.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", bus_a.out_valid); else n_pass++;
        n_total++; if (bus_a.in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", bus_a.in_ready); else n_pass++;
        n_total++; if (bus_a.data_out_0 !== '0) $display("FAIL mid_data_out_0: got %h want 0", bus_a.data_out_0); else n_pass++;
        n_total++; if (bus_a.data_out_1 !== '0) $display("FAIL mid_data_out_1: got %h want 0", bus_a.data_out_1); else n_pass++;
        reset = 1'b0;
        clear_model();
        plan_v.push_back(1'b1); plan_f.push_back(ramp(50));
        run(0, 8);
        n_total++;
        if (tr_ov[0] !== 1'b0) $display("FAIL mid_idle_after: got valid=%b want 0", tr_ov[0]);
        else n_pass++;
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL mid_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL mid_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                plan_v.push_back($urandom_range(0, 2) == 0);
                plan_f.push_back(rand_frame());
                plan_r.push_back($urandom_range(0, 3) != 0);
            end
            run(s, 360);
            for (int c = 0; c < 360; c++) begin
                n_total++;
                if (tr_ir[c] !== tr_mrdy[c]) $display("FAIL rand%0d_in_ready_c%0d: got %b want %b", s, c, tr_ir[c], tr_mrdy[c]);
                else n_pass++;
            end
            n_total++;
            if (obs_q.size() !== exp_q.size()) $display("FAIL rand%0d_count: got %0d beats want %0d", s, obs_q.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_total++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_beat%0d: got %h want %h", s, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_no_prefix();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
